// File: rtl/matrix_writeback.sv
// ---------------------------------------------------------------------------
// matrix_writeback
//
// Takes a snapshot of an 8x8 byte matrix when start is seen in IDLE. It then
// streams the 64 bytes out through a ready/valid write port, one accepted
// byte per cycle, to consecutive (wrapping) 6-bit addresses that begin at
// BASE_ADDR. Element order is row-major (k = row*8+col) or column-major
// (k = col*8+row), chosen by COL_MAJOR.
//
// Parameters
//   BASE_ADDR  6-bit address of element 0; element k goes to BASE_ADDR+k mod 64
//   COL_MAJOR  0 = row-major element order, 1 = column-major element order
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   snapshot + write-out request, only looked at in IDLE
//   matrix    in   8x8 source bytes, matrix[row][col]
//   wr_ready  in   sink accepts the current write this cycle
//   wr_en     out  write valid (registered)
//   wr_addr   out  write address (registered)
//   wr_data   out  write byte (registered)
//   busy      out  high while writing or signalling done
//   done      out  one-cycle pulse after the 64th accepted write (registered)
// ---------------------------------------------------------------------------
module matrix_writeback #(
    parameter logic [5:0] BASE_ADDR = 6'd0,
    parameter bit         COL_MAJOR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [0:7][0:7][7:0] matrix,
    input  logic                 wr_ready,
    output logic                 wr_en,
    output logic [5:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]           state;
    logic [5:0]           index;
    logic [0:7][0:7][7:0] snapshot;
    logic [5:0]           next_index;
    logic [5:0]           next_pos;

    // The snapshot is always stored in source (row-major) layout, so a
    // column-major element index only needs its row/column halves swapped
    // to find the byte.
    function automatic logic [5:0] elem_pos(input logic [5:0] k);
        if (COL_MAJOR)
            return {k[2:0], k[5:3]};
        else
            return k;
    endfunction

    assign next_index = index + 6'd1;
    assign next_pos   = elem_pos(next_index);
    assign busy       = (state == WRITE) || (state == DONE);

    // Snapshot capture. It has no reset because its contents only matter
    // after a capture, and a capture happens on the same edge that leaves
    // IDLE.
    always_ff @(posedge clk) begin
        if (state == IDLE && start)
            snapshot <= matrix;
    end

    // Control FSM and registered write port. wr_en is high for the whole
    // of WRITE, so a transfer is simply WRITE with wr_ready. Each output
    // register is loaded one element ahead, so a stall leaves it untouched.
    // The first element is taken straight from the live matrix because the
    // snapshot is written on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            index   <= 6'd0;
            wr_en   <= 1'b0;
            wr_addr <= 6'd0;
            wr_data <= 8'd0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= WRITE;
                        index   <= 6'd0;
                        wr_en   <= 1'b1;
                        wr_addr <= BASE_ADDR;
                        wr_data <= matrix[0][0];
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        if (index == 6'd63) begin
                            state <= DONE;
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index   <= next_index;
                            wr_addr <= BASE_ADDR + next_index;
                            wr_data <= snapshot[next_pos[5:3]][next_pos[2:0]];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    index <= 6'd0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_writeback.sv
// ---------------------------------------------------------------------------
// tb_matrix_writeback
//
// Three instances share one stimulus stream: row-major at base 0,
// column-major at base 0, and row-major at base 60. Each recorded write
// sequence is compared against a reference built from the captured matrix
// with plain index arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matrix_writeback;

    localparam int NI     = 3;
    localparam int BUDGET = 1000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [0:7][0:7][7:0] matrix;
    logic                 wr_ready;

    logic [NI-1:0]        wr_en_v;
    logic [NI-1:0]        busy_v;
    logic [NI-1:0]        done_v;
    logic [NI-1:0][5:0]   wr_addr_v;
    logic [NI-1:0][7:0]   wr_data_v;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [0:7][0:7][7:0] snap;
    logic [5:0] obs_addr [NI][128];
    logic [7:0] obs_data [NI][128];
    int  obs_cnt   [NI];
    int  done_cnt  [NI];
    int  done_cyc  [NI];
    int  first_en  [NI];
    int  last_xfer [NI];
    int  en_cycles [NI];
    int  stall_err [NI];
    int  busy_err  [NI];
    bit  prev_stall[NI];
    logic [5:0] prev_addr [NI];
    logic [7:0] prev_data [NI];
    bit  en_log [BUDGET];
    bit  aborted;

    always #5 clk = ~clk;

    matrix_writeback #(.BASE_ADDR(6'd0), .COL_MAJOR(1'b0)) dut_row (
        .clk(clk), .rst(rst), .start(start), .matrix(matrix), .wr_ready(wr_ready),
        .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));

    matrix_writeback #(.BASE_ADDR(6'd0), .COL_MAJOR(1'b1)) dut_col (
        .clk(clk), .rst(rst), .start(start), .matrix(matrix), .wr_ready(wr_ready),
        .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));

    matrix_writeback #(.BASE_ADDR(6'd60), .COL_MAJOR(1'b0)) dut_b60 (
        .clk(clk), .rst(rst), .start(start), .matrix(matrix), .wr_ready(wr_ready),
        .wr_en(wr_en_v[2]), .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));

    // Reference model: where and what the k-th write of instance i should be.
    function automatic int base_of(input int i);
        return (i == 2) ? 60 : 0;
    endfunction

    function automatic int exp_addr(input int i, input int k);
        return (base_of(i) + k) % 64;
    endfunction

    function automatic int exp_data(input int i, input int k);
        int r;
        int c;
        if (i == 1) begin
            r = k % 8;
            c = k / 8;
        end else begin
            r = k / 8;
            c = k % 8;
        end
        return int'(snap[r][c]);
    endfunction

    task automatic fill_matrix(input bit use_pattern);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                matrix[r][c] = use_pattern ? 8'(r * 8 + c) : 8'($urandom_range(0, 254));
    endtask

    // Issues one start and then records every cycle on all three instances
    // until a few cycles after the last done, or until BUDGET runs out. It can
    // optionally re-raise start at a given write count, assert rst at a given
    // write count, or hold start high throughout.
    task automatic run_xfer(input bit rand_ready, input bit overwrite, input bit use_pattern,
                            input int restart_at, input int abort_at, input bit hold_start);
        int  cyc;
        int  stop_at;
        bit  all_done;
        for (int i = 0; i < NI; i++) begin
            obs_cnt[i]    = 0;
            done_cnt[i]   = 0;
            done_cyc[i]   = -1;
            first_en[i]   = -1;
            last_xfer[i]  = -1;
            en_cycles[i]  = 0;
            stall_err[i]  = 0;
            busy_err[i]   = 0;
            prev_stall[i] = 1'b0;
        end
        for (int j = 0; j < BUDGET; j++) en_log[j] = 1'b0;
        aborted = 1'b0;

        @(posedge clk); #1;
        fill_matrix(use_pattern);
        snap     = matrix;
        start    = 1'b1;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        if (overwrite)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    matrix[r][c] = 8'hFF;

        cyc     = 0;
        stop_at = BUDGET;
        while (cyc < stop_at) begin
            if (abort_at >= 0 && obs_cnt[0] == abort_at) begin
                start   = 1'b0;
                rst     = 1'b1;
                #2;
                aborted = 1'b1;
                return;
            end
            start    = hold_start || (restart_at >= 0 && obs_cnt[0] == restart_at);
            wr_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (busy_v[i] !== (wr_en_v[i] | done_v[i])) busy_err[i]++;
                if (prev_stall[i] && (wr_en_v[i] !== 1'b1 || wr_addr_v[i] !== prev_addr[i] ||
                                      wr_data_v[i] !== prev_data[i]))
                    stall_err[i]++;
                if (wr_en_v[i] === 1'b1) begin
                    en_cycles[i]++;
                    if (first_en[i] < 0) first_en[i] = cyc;
                    if (wr_ready) begin
                        if (obs_cnt[i] < 128) begin
                            obs_addr[i][obs_cnt[i]] = wr_addr_v[i];
                            obs_data[i][obs_cnt[i]] = wr_data_v[i];
                        end
                        obs_cnt[i]++;
                        last_xfer[i] = cyc;
                    end
                end
                prev_stall[i] = (wr_en_v[i] === 1'b1) && !wr_ready;
                prev_addr[i]  = wr_addr_v[i];
                prev_data[i]  = wr_data_v[i];
                if (done_v[i] === 1'b1) begin
                    done_cnt[i]++;
                    if (done_cyc[i] < 0) done_cyc[i] = cyc;
                end
            end
            en_log[cyc] = wr_en_v[0];
            all_done = 1'b1;
            for (int i = 0; i < NI; i++) if (done_cyc[i] < 0) all_done = 1'b0;
            if (all_done && stop_at == BUDGET) stop_at = cyc + 4;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (wr_en_v[i] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_wr_en inst%0d: got %b, expected 0", i, wr_en_v[i]);
            end
            tests_run++;
            if (wr_addr_v[i] !== 6'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_wr_addr inst%0d: got %0d, expected 0", i, wr_addr_v[i]);
            end
            tests_run++;
            if (wr_data_v[i] !== 8'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_wr_data inst%0d: got %0d, expected 0", i, wr_data_v[i]);
            end
            tests_run++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_busy_done inst%0d: got %b%b, expected 00", i, busy_v[i], done_v[i]);
            end
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_ordering();
        run_xfer(1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (obs_cnt[i] != 64) begin
                tests_failed++;
                $display("[TB] FAIL order_count inst%0d: got %0d, expected 64", i, obs_cnt[i]);
            end
            for (int k = 0; k < 64 && k < obs_cnt[i]; k++) begin
                tests_run++;
                if (int'(obs_addr[i][k]) != exp_addr(i, k) || int'(obs_data[i][k]) != exp_data(i, k)) begin
                    tests_failed++;
                    $display("[TB] FAIL order_write inst%0d k=%0d: got addr %0d data %0d, expected addr %0d data %0d",
                             i, k, obs_addr[i][k], obs_data[i][k], exp_addr(i, k), exp_data(i, k));
                end
            end
            tests_run++;
            if (first_en[i] != 0 || en_cycles[i] != 64 || last_xfer[i] != 63) begin
                tests_failed++;
                $display("[TB] FAIL order_timing inst%0d: got first %0d cycles %0d last %0d, expected 0 64 63",
                         i, first_en[i], en_cycles[i], last_xfer[i]);
            end
            tests_run++;
            if (done_cnt[i] != 1 || done_cyc[i] != 64) begin
                tests_failed++;
                $display("[TB] FAIL order_done inst%0d: got count %0d at %0d, expected 1 at 64",
                         i, done_cnt[i], done_cyc[i]);
            end
            tests_run++;
            if (busy_err[i] != 0) begin
                tests_failed++;
                $display("[TB] FAIL order_busy inst%0d: got %0d bad cycles, expected 0", i, busy_err[i]);
            end
        end
        tests_run++;
        if (obs_cnt[1] < 3 || obs_data[1][0] !== 8'h00 || obs_data[1][1] !== 8'h08 || obs_data[1][2] !== 8'h10) begin
            tests_failed++;
            $display("[TB] FAIL colmajor_head: got %h %h %h, expected 00 08 10",
                     obs_data[1][0], obs_data[1][1], obs_data[1][2]);
        end
    endtask

    task automatic test_stall_overwrite();
        int ff_seen;
        run_xfer(1'b1, 1'b1, 1'b0, -1, -1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            ff_seen = 0;
            tests_run++;
            if (obs_cnt[i] != 64) begin
                tests_failed++;
                $display("[TB] FAIL stall_count inst%0d: got %0d, expected 64", i, obs_cnt[i]);
            end
            for (int k = 0; k < 64 && k < obs_cnt[i]; k++) begin
                if (obs_data[i][k] === 8'hFF) ff_seen++;
                tests_run++;
                if (int'(obs_addr[i][k]) != exp_addr(i, k) || int'(obs_data[i][k]) != exp_data(i, k)) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_write inst%0d k=%0d: got addr %0d data %0d, expected addr %0d data %0d",
                             i, k, obs_addr[i][k], obs_data[i][k], exp_addr(i, k), exp_data(i, k));
                end
            end
            tests_run++;
            if (ff_seen != 0) begin
                tests_failed++;
                $display("[TB] FAIL stall_no_ff inst%0d: got %0d bytes of FF, expected 0", i, ff_seen);
            end
            tests_run++;
            if (stall_err[i] != 0) begin
                tests_failed++;
                $display("[TB] FAIL stall_stable inst%0d: got %0d unstable stalls, expected 0", i, stall_err[i]);
            end
            tests_run++;
            if (done_cnt[i] != 1 || done_cyc[i] != last_xfer[i] + 1) begin
                tests_failed++;
                $display("[TB] FAIL stall_done inst%0d: got count %0d at %0d, expected 1 at %0d",
                         i, done_cnt[i], done_cyc[i], last_xfer[i] + 1);
            end
            tests_run++;
            if (busy_err[i] != 0) begin
                tests_failed++;
                $display("[TB] FAIL stall_busy inst%0d: got %0d bad cycles, expected 0", i, busy_err[i]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        run_xfer(1'b1, 1'b0, 1'b0, 20, -1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (obs_cnt[i] != 64 || done_cnt[i] != 1) begin
                tests_failed++;
                $display("[TB] FAIL restart_count inst%0d: got %0d writes %0d done, expected 64 writes 1 done",
                         i, obs_cnt[i], done_cnt[i]);
            end
        end
        for (int k = 0; k < 64 && k < obs_cnt[0]; k++) begin
            tests_run++;
            if (int'(obs_addr[0][k]) != exp_addr(0, k) || int'(obs_data[0][k]) != exp_data(0, k)) begin
                tests_failed++;
                $display("[TB] FAIL restart_write k=%0d: got addr %0d data %0d, expected addr %0d data %0d",
                         k, obs_addr[0][k], obs_data[0][k], exp_addr(0, k), exp_data(0, k));
            end
        end
    endtask

    task automatic test_reset_abort();
        run_xfer(1'b0, 1'b0, 1'b0, -1, 30, 1'b0);
        tests_run++;
        if (!aborted) begin
            tests_failed++;
            $display("[TB] FAIL abort_reached: got %0d writes, expected to reach 30", obs_cnt[0]);
        end
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (wr_en_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL abort_async inst%0d: got en %b busy %b done %b, expected 0 0 0",
                         i, wr_en_v[i], busy_v[i], done_v[i]);
            end
            tests_run++;
            if (done_cnt[i] != 0) begin
                tests_failed++;
                $display("[TB] FAIL abort_no_done inst%0d: got %0d done pulses, expected 0", i, done_cnt[i]);
            end
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run_xfer(1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (obs_cnt[i] != 64 || done_cnt[i] != 1) begin
                tests_failed++;
                $display("[TB] FAIL after_abort_count inst%0d: got %0d writes %0d done, expected 64 writes 1 done",
                         i, obs_cnt[i], done_cnt[i]);
            end
            tests_run++;
            if (obs_cnt[i] < 1 || int'(obs_addr[i][0]) != base_of(i) || int'(obs_data[i][0]) != exp_data(i, 0)) begin
                tests_failed++;
                $display("[TB] FAIL after_abort_first inst%0d: got addr %0d data %0d, expected addr %0d data %0d",
                         i, obs_addr[i][0], obs_data[i][0], base_of(i), exp_data(i, 0));
            end
        end
        for (int k = 0; k < 64 && k < obs_cnt[2]; k++) begin
            tests_run++;
            if (int'(obs_addr[2][k]) != exp_addr(2, k) || int'(obs_data[2][k]) != exp_data(2, k)) begin
                tests_failed++;
                $display("[TB] FAIL after_abort_write k=%0d: got addr %0d data %0d, expected addr %0d data %0d",
                         k, obs_addr[2][k], obs_data[2][k], exp_addr(2, k), exp_data(2, k));
            end
        end
    endtask

    task automatic test_start_held();
        int d;
        run_xfer(1'b0, 1'b0, 1'b0, -1, -1, 1'b1);
        d = done_cyc[0];
        tests_run++;
        if (d < 0 || done_cnt[0] != 1) begin
            tests_failed++;
            $display("[TB] FAIL held_done: got count %0d at %0d, expected 1 pulse", done_cnt[0], d);
        end else begin
            tests_run++;
            if (en_log[d + 1] !== 1'b0 || en_log[d + 2] !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL held_restart: got wr_en %b then %b after done, expected 0 then 1",
                         en_log[d + 1], en_log[d + 2]);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        wr_ready = 1'b0;
        matrix   = '0;
        #2;
        test_reset();
        test_ordering();
        test_stall_overwrite();
        test_restart_ignored();
        test_reset_abort();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/matrix_writeback.md
MATRIX_WRITEBACK -- requirements
Module: matrix_writeback

Interface
REQ-001 Parameter BASE_ADDR, default 0, 6-bit start address; element index k is written to (BASE_ADDR + k) mod 64.
REQ-002 Parameter COL_MAJOR, default 0; 0 = row-major index k = row*8+col, 1 = column-major index k = col*8+row.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to snapshot and write out the matrix; sampled only in IDLE.
REQ-006 matrix  input  8 x [0:7][0:7]  source 8x8 byte matrix.
REQ-007 wr_ready  input  1  sink accepts the current write this cycle.
REQ-008 wr_en  output  1  write valid.
REQ-009 wr_addr  output  6  write address.
REQ-010 wr_data  output  8  write byte.
REQ-011 busy  output  1  high in WRITE and DONE states.
REQ-012 done  output  1  one-cycle pulse after the 64th accepted write.

Function
REQ-013 States: IDLE, WRITE, DONE.
REQ-014 IDLE with start=1 -> capture all 64 bytes of matrix into an internal snapshot, clear index to 0, go to WRITE on the next edge.
REQ-015 Snapshot is held for the whole transfer; matrix changes after the capture edge do not affect wr_data.
REQ-016 WRITE: wr_en=1, wr_addr=(BASE_ADDR+index) mod 64, wr_data=snapshot element for index per COL_MAJOR.
REQ-017 Transfer occurs on each edge where wr_en=1 and wr_ready=1; index increments by 1 only on a transfer.
REQ-018 While wr_ready=0, wr_en, wr_addr and wr_data hold stable; no element is skipped or repeated.
REQ-019 Transfer with index=63 -> go to DONE; wr_en=0 from the next cycle.
REQ-020 DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-021 wr_en, wr_addr, wr_data and done are registered outputs; wr_addr wraps 63->0 when BASE_ADDR>0.
REQ-022 start in WRITE or DONE is ignored and not queued.
REQ-023 start held high continuously -> a new transfer begins on the first IDLE cycle after DONE.
REQ-024 Minimum latency from start to first transfer is 1 cycle; an uninterrupted transfer takes 64 cycles of wr_en; done occurs 1 cycle after the last transfer.

Reset
REQ-025 rst=1 forces IDLE immediately, regardless of clk; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, index=0.
REQ-026 rst asserted mid-transfer aborts without a done pulse; after release a new start begins at index 0.
REQ-027 Snapshot contents need no reset value.

Verification
REQ-028 matrix[r][c]=r*8+c, BASE_ADDR=0, wr_ready=1, start pulse -> 64 writes addr k, data k on consecutive cycles; done pulses once 1 cycle after addr 63.
REQ-029 Same matrix, COL_MAJOR=1 -> write k carries data (k%8)*8+k/8; first three bytes 0x00,0x08,0x10.
REQ-030 BASE_ADDR=60 -> addresses 60,61,62,63,0,...,59; data still follows index 0..63.
REQ-031 wr_ready toggled pseudo-randomly, matrix overwritten with 0xFF after start -> each original byte appears exactly once, in order, outputs stable during stalls, no 0xFF data.
REQ-032 Second start pulse at index 20 -> ignored; exactly 64 writes and one done.
REQ-033 rst asserted at index 30 -> wr_en=0 and busy=0 without waiting for clk, no done; next start writes from addr BASE_ADDR.
